// File: rtl/oled_defs.sv
// Shared definitions for the SSD1306 command/data sequencer.
// State encodings, I2C control bytes, init length, page-address base.
// Purely declarative; no latency or backpressure of its own.
package oled_defs;

    // Sequencer state encodings
    localparam logic [2:0] ST_PWR_WAIT   = 3'd0;
    localparam logic [2:0] ST_INIT_ISSUE = 3'd1;
    localparam logic [2:0] ST_INIT_WAIT  = 3'd2;
    localparam logic [2:0] ST_CLR_ISSUE  = 3'd3;
    localparam logic [2:0] ST_CLR_WAIT   = 3'd4;
    localparam logic [2:0] ST_READY      = 3'd5;
    localparam logic [2:0] ST_USR_WAIT   = 3'd6;
    localparam logic [2:0] ST_ERROR      = 3'd7;

    // SSD1306 control bytes: Co=0, D/C#=0 for commands, D/C#=1 for GDDRAM data
    localparam logic [7:0] CTRL_CMD  = 8'h00;
    localparam logic [7:0] CTRL_DATA = 8'h40;

    localparam int unsigned INIT_LEN = 25;

    // Page-address command, page number ORed into the low bits
    localparam logic [7:0] PAGE_BASE = 8'hB0;

    // States in which a driver transaction is outstanding and the watchdog runs
    function automatic logic is_wait_state(input logic [2:0] st);
        return (st == ST_INIT_WAIT) || (st == ST_CLR_WAIT) || (st == ST_USR_WAIT);
    endfunction

endpackage

// File: rtl/oled_init_rom.sv
// SSD1306 power-on init byte table, 25 entries.
// Latency: combinational, index to byte in the same cycle.
// Backpressure: none; out-of-range indices return 8'h00.
//
// Ports:
//   idx      - entry index 0..24
//   rom_byte - init command byte at that index
module oled_init_rom (
    input  logic [4:0] idx,
    output logic [7:0] rom_byte
);

    always_comb begin
        rom_byte = 8'h00;
        case (idx)
            5'd0:  rom_byte = 8'hAE;  // display off
            5'd1:  rom_byte = 8'hD5;  // clock divide / oscillator
            5'd2:  rom_byte = 8'h80;
            5'd3:  rom_byte = 8'hA8;  // multiplex ratio
            5'd4:  rom_byte = 8'h3F;
            5'd5:  rom_byte = 8'hD3;  // display offset
            5'd6:  rom_byte = 8'h00;
            5'd7:  rom_byte = 8'h40;  // start line 0
            5'd8:  rom_byte = 8'h8D;  // charge pump
            5'd9:  rom_byte = 8'h14;
            5'd10: rom_byte = 8'h20;  // memory addressing mode
            5'd11: rom_byte = 8'h02;  // page addressing
            5'd12: rom_byte = 8'hA1;  // segment remap
            5'd13: rom_byte = 8'hC8;  // COM scan direction
            5'd14: rom_byte = 8'hDA;  // COM pins
            5'd15: rom_byte = 8'h12;
            5'd16: rom_byte = 8'h81;  // contrast
            5'd17: rom_byte = 8'hCF;
            5'd18: rom_byte = 8'hD9;  // pre-charge
            5'd19: rom_byte = 8'hF1;
            5'd20: rom_byte = 8'hDB;  // VCOMH deselect
            5'd21: rom_byte = 8'h40;
            5'd22: rom_byte = 8'hA4;  // resume from RAM
            5'd23: rom_byte = 8'hA6;  // normal (non-inverted)
            5'd24: rom_byte = 8'hAF;  // display on
            default: rom_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/oled_i2c_seq.sv
// SSD1306 command/data sequencer: power-up delay, ROM init, optional frame clear, then user byte writes.
// Latency: usr_req -> drv_exec 1 cycle, drv_done -> usr_ack 1 cycle, >=2 idle cycles between done and next exec.
// Backpressure: usr_req is a level held until usr_ack; accepted only while ready; a missing drv_done trips a sticky err.
//
// Optional feature: define OLED_CLEAR_EN to zero-fill all PAGES x COLS of GDDRAM after init.
//
// Ports:
//   i2c_clk, rst_n              - driver clock, async active-low reset
//   usr_req/usr_cmd/usr_byte    - user write request (cmd=1 command, cmd=0 GDDRAM data)
//   usr_ack, ready, err         - completion pulse, accepting, sticky timeout flag
//   drv_exec/drv_we/drv_addr_hl - start pulse and fixed write controls to the I2C byte driver
//   drv_word_addr, drv_wdata    - {8'h00, control byte} and payload byte
//   drv_done                    - one-cycle completion pulse from the driver
module oled_i2c_seq
    import oled_defs::*;
#(
    parameter logic [15:0] PWR_DLY = 16'd1000,
    parameter logic [15:0] TIMEOUT = 16'd4000,
    parameter int unsigned COLS    = 128,
    parameter int unsigned PAGES   = 8
) (
    input  logic        i2c_clk,
    input  logic        rst_n,
    input  logic        usr_req,
    input  logic        usr_cmd,
    input  logic [7:0]  usr_byte,
    output logic        usr_ack,
    output logic        ready,
    output logic        err,
    output logic        drv_exec,
    output logic        drv_we,
    output logic        drv_addr_hl,
    output logic [15:0] drv_word_addr,
    output logic [7:0]  drv_wdata,
    input  logic        drv_done
);

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;        // power-up delay, then per-transaction watchdog
    logic [4:0]  idx_q, idx_d;
    logic        exec_q, exec_d;
    logic        ack_q, ack_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rom_byte;
    logic        usr_accept;

`ifdef OLED_CLEAR_EN
    localparam int unsigned COL_W = $clog2(COLS + 1);
    localparam int unsigned PG_W  = (PAGES > 1) ? $clog2(PAGES) : 1;

    logic [PG_W-1:0]  pg_q, pg_d;
    logic [COL_W-1:0] col_q, col_d;
    // 0..2: page/column-address commands of the current page, 3: data bytes
    logic [1:0]       cstep_q, cstep_d;
`endif

    oled_init_rom u_rom (
        .idx      (idx_q),
        .rom_byte (rom_byte)
    );

    // ready_q gates acceptance so a request still held during the usr_ack
    // cycle is not mistaken for a new one.
    assign usr_accept = (state_q == ST_READY) && ready_q && usr_req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        exec_d  = 1'b0;
        ack_d   = 1'b0;
        ready_d = 1'b0;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef OLED_CLEAR_EN
        pg_d    = pg_q;
        col_d   = col_q;
        cstep_d = cstep_q;
`endif

        case (state_q)
            ST_PWR_WAIT: begin
                if (cnt_q == PWR_DLY - 16'd1) begin
                    cnt_d   = 16'd0;
                    idx_d   = 5'd0;
                    state_d = ST_INIT_ISSUE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ST_INIT_ISSUE: begin
                addr_d  = {8'h00, CTRL_CMD};
                wdata_d = rom_byte;
                exec_d  = 1'b1;
                cnt_d   = 16'd0;
                state_d = ST_INIT_WAIT;
            end

            ST_INIT_WAIT: begin
                if (drv_done) begin
                    idx_d = idx_q + 5'd1;
                    if (idx_q == 5'(INIT_LEN - 1)) begin
`ifdef OLED_CLEAR_EN
                        pg_d    = '0;
                        col_d   = '0;
                        cstep_d = 2'd0;
                        state_d = ST_CLR_ISSUE;
`else
                        state_d = ST_READY;
`endif
                    end else begin
                        state_d = ST_INIT_ISSUE;
                    end
                end
            end

`ifdef OLED_CLEAR_EN
            ST_CLR_ISSUE: begin
                case (cstep_q)
                    2'd0:    begin addr_d = {8'h00, CTRL_CMD};  wdata_d = PAGE_BASE | 8'(pg_q); end
                    2'd1:    begin addr_d = {8'h00, CTRL_CMD};  wdata_d = 8'h00; end  // column low nibble
                    2'd2:    begin addr_d = {8'h00, CTRL_CMD};  wdata_d = 8'h10; end  // column high nibble
                    default: begin addr_d = {8'h00, CTRL_DATA}; wdata_d = 8'h00; end
                endcase
                exec_d  = 1'b1;
                cnt_d   = 16'd0;
                state_d = ST_CLR_WAIT;
            end

            ST_CLR_WAIT: begin
                if (drv_done) begin
                    if (cstep_q != 2'd3) begin
                        cstep_d = cstep_q + 2'd1;
                        state_d = ST_CLR_ISSUE;
                    end else if (col_q == COL_W'(COLS - 1)) begin
                        col_d = '0;
                        if (pg_q == PG_W'(PAGES - 1)) begin
                            state_d = ST_READY;
                        end else begin
                            pg_d    = pg_q + PG_W'(1);
                            cstep_d = 2'd0;
                            state_d = ST_CLR_ISSUE;
                        end
                    end else begin
                        col_d   = col_q + COL_W'(1);
                        state_d = ST_CLR_ISSUE;
                    end
                end
            end
`endif

            ST_READY: begin
                ready_d = 1'b1;
                if (usr_accept) begin
                    addr_d  = {8'h00, (usr_cmd ? CTRL_CMD : CTRL_DATA)};
                    wdata_d = usr_byte;
                    exec_d  = 1'b1;
                    cnt_d   = 16'd0;
                    ready_d = 1'b0;
                    state_d = ST_USR_WAIT;
                end
            end

            ST_USR_WAIT: begin
                if (drv_done) begin
                    ack_d   = 1'b1;
                    state_d = ST_READY;
                end
            end

            ST_ERROR: begin
                state_d = ST_ERROR;
            end

            default: begin
                state_d = ST_PWR_WAIT;
            end
        endcase

        // Watchdog: a done on the terminal-count cycle takes the branch above
        // and never reaches this check, so done wins the tie.
        if (is_wait_state(state_q) && !drv_done) begin
            if (cnt_q == TIMEOUT - 16'd1) begin
                state_d = ST_ERROR;
                err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge i2c_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_PWR_WAIT;
            cnt_q   <= 16'd0;
            idx_q   <= 5'd0;
            exec_q  <= 1'b0;
            ack_q   <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            exec_q  <= exec_d;
            ack_q   <= ack_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef OLED_CLEAR_EN
    always_ff @(posedge i2c_clk or negedge rst_n) begin
        if (!rst_n) begin
            pg_q    <= '0;
            col_q   <= '0;
            cstep_q <= 2'd0;
        end else begin
            pg_q    <= pg_d;
            col_q   <= col_d;
            cstep_q <= cstep_d;
        end
    end
`endif

    assign drv_exec      = exec_q;
    assign drv_we        = 1'b1;
    assign drv_addr_hl   = 1'b0;
    assign drv_word_addr = addr_q;
    assign drv_wdata     = wdata_q;
    assign usr_ack       = ack_q;
    assign ready         = ready_q;
    assign err           = err_q;

endmodule

// File: tb/tb_oled_i2c_seq.sv
// Self-checking bench for oled_i2c_seq: behavioural I2C driver model plus an
// expected transaction list built from the panel init table and clear rules.
// Latency/backpressure checks are done against absolute cycle numbers.
module tb_oled_i2c_seq;

    localparam logic [15:0] PWR_DLY = 16'd20;
    localparam logic [15:0] TIMEOUT = 16'd60;
    localparam int COLS   = 16;
    localparam int PAGES  = 8;
    localparam int INIT_N = 25;
`ifdef OLED_CLEAR_EN
    localparam int CLR_N   = PAGES * (3 + COLS);
    localparam int MID_IDX = INIT_N + 5 * (3 + COLS) + 4;   // a data byte of page 5
`else
    localparam int CLR_N   = 0;
    localparam int MID_IDX = 12;
`endif
    localparam int SEQ_N = INIT_N + CLR_N;

    logic        i2c_clk;
    logic        rst_n;
    logic        usr_req;
    logic        usr_cmd;
    logic [7:0]  usr_byte;
    logic        usr_ack;
    logic        ready;
    logic        err;
    logic        drv_exec;
    logic        drv_we;
    logic        drv_addr_hl;
    logic [15:0] drv_word_addr;
    logic [7:0]  drv_wdata;
    logic        drv_done;

    oled_i2c_seq #(
        .PWR_DLY (PWR_DLY),
        .TIMEOUT (TIMEOUT),
        .COLS    (COLS),
        .PAGES   (PAGES)
    ) dut (
        .i2c_clk       (i2c_clk),
        .rst_n         (rst_n),
        .usr_req       (usr_req),
        .usr_cmd       (usr_cmd),
        .usr_byte      (usr_byte),
        .usr_ack       (usr_ack),
        .ready         (ready),
        .err           (err),
        .drv_exec      (drv_exec),
        .drv_we        (drv_we),
        .drv_addr_hl   (drv_addr_hl),
        .drv_word_addr (drv_word_addr),
        .drv_wdata     (drv_wdata),
        .drv_done      (drv_done)
    );

    logic [7:0] rom_ref [INIT_N] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
        8'h20, 8'h02, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
        8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Driver model state
    int          fixed_dly = 0;   // 0 = random delay per transaction
    bit          withhold  = 0;
    bit          pend      = 0;
    int          pcnt      = 0;
    int          done_cyc  = -100;
    int          stab_bad  = 0;
    int          gap_bad   = 0;
    logic [15:0] cur_addr;
    logic [7:0]  cur_data;
    logic [15:0] log_addr[$];
    logic [7:0]  log_data[$];
    int          log_cyc[$];
    logic [15:0] exp_addr[$];
    logic [7:0]  exp_data[$];

    initial begin
        i2c_clk = 1'b0;
        forever #5 i2c_clk = ~i2c_clk;
    end

    initial begin
        forever begin
            @(posedge i2c_clk);
            cyc = cyc + 1;
        end
    end

    // Behavioural I2C byte driver: logs every exec, answers with drv_done after a delay.
    initial begin
        drv_done = 1'b0;
        forever begin
            @(negedge i2c_clk);
            drv_done = 1'b0;
            if (rst_n !== 1'b1) begin
                pend = 0;
            end else if (pend) begin
                if (drv_word_addr !== cur_addr || drv_wdata !== cur_data) stab_bad++;
                if (drv_exec === 1'b1) stab_bad++;
                if (pcnt <= 1) begin
                    drv_done = 1'b1;
                    pend     = 0;
                    done_cyc = cyc;
                end else begin
                    pcnt--;
                end
            end else if (drv_exec === 1'b1) begin
                if (cyc < done_cyc + 2) gap_bad++;
                log_addr.push_back(drv_word_addr);
                log_data.push_back(drv_wdata);
                log_cyc.push_back(cyc);
                cur_addr = drv_word_addr;
                cur_data = drv_wdata;
                if (!withhold) begin
                    pend = 1;
                    pcnt = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 12));
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

    task automatic tick;
        @(negedge i2c_clk);
        #1;
    endtask

    task automatic release_reset(output int rel);
        tick();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
        rst_n = 1'b1;
        rel   = cyc;
    endtask

    task automatic build_exp;
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < INIT_N; i++) begin
            exp_addr.push_back(16'h0000);
            exp_data.push_back(rom_ref[i]);
        end
`ifdef OLED_CLEAR_EN
        for (int p = 0; p < PAGES; p++) begin
            exp_addr.push_back(16'h0000); exp_data.push_back(8'hB0 + 8'(p));
            exp_addr.push_back(16'h0000); exp_data.push_back(8'h00);
            exp_addr.push_back(16'h0000); exp_data.push_back(8'h10);
            for (int c = 0; c < COLS; c++) begin
                exp_addr.push_back(16'h0040);
                exp_data.push_back(8'h00);
            end
        end
`endif
    endtask

    // Stimulus only: one user write, returning the observed cycle numbers.
    task automatic do_write(input logic c, input logic [7:0] b,
                            output int creq, output int cex, output int cack,
                            output logic rdy_ex, output logic rdy_ack, output logic rdy_after);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 500) begin tick(); n++; end
        usr_cmd  = c;
        usr_byte = b;
        usr_req  = 1'b1;
        creq     = cyc;
        n = 0;
        do begin tick(); n++; end while (drv_exec !== 1'b1 && n < 500);
        cex    = cyc;
        rdy_ex = ready;
        n = 0;
        do begin tick(); n++; end while (usr_ack !== 1'b1 && n < 500);
        cack    = cyc;
        rdy_ack = ready;
        usr_req = 1'b0;
        tick();
        rdy_after = ready;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (drv_exec !== 1'b0)          begin errors++; $display("FAIL rst_exec got=%b exp=0", drv_exec); end
        checks++; if (usr_ack !== 1'b0)           begin errors++; $display("FAIL rst_ack got=%b exp=0", usr_ack); end
        checks++; if (ready !== 1'b0)             begin errors++; $display("FAIL rst_ready got=%b exp=0", ready); end
        checks++; if (err !== 1'b0)               begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
        checks++; if (drv_word_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr got=%h exp=0000", drv_word_addr); end
        checks++; if (drv_wdata !== 8'h00)        begin errors++; $display("FAIL rst_wdata got=%h exp=00", drv_wdata); end
        checks++; if (drv_we !== 1'b1)            begin errors++; $display("FAIL rst_we got=%b exp=1", drv_we); end
        checks++; if (drv_addr_hl !== 1'b0)       begin errors++; $display("FAIL rst_addr_hl got=%b exp=0", drv_addr_hl); end
    endtask

    task automatic test_init;
        int rel;
        int n;
        int first;
        int sz;
        fixed_dly = 50;
        build_exp();
        release_reset(rel);
        n = 0;
        while (ready !== 1'b1 && n < 20000) begin tick(); n++; end
        sz    = log_data.size();
        first = (log_cyc.size() > 0) ? log_cyc[0] - rel : -1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL init_ready got=%b exp=1 after %0d cycles", ready, n); end
        checks++; if (first != int'(PWR_DLY) + 1) begin errors++; $display("FAIL init_first_exec_cycle got=%0d exp=%0d", first, int'(PWR_DLY) + 1); end
        checks++; if (sz != SEQ_N) begin errors++; $display("FAIL init_txn_count_at_ready got=%0d exp=%0d", sz, SEQ_N); end
        checks++; if (cyc != done_cyc + 2) begin errors++; $display("FAIL init_ready_rise got=%0d exp=%0d", cyc, done_cyc + 2); end
        for (int i = 0; i < SEQ_N; i++) begin
            checks++;
            if (i >= sz) begin
                errors++; $display("FAIL init_seq[%0d] missing exp=%h/%h", i, exp_addr[i], exp_data[i]);
            end else if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL init_seq[%0d] got=%h/%h exp=%h/%h", i, log_addr[i], log_data[i], exp_addr[i], exp_data[i]);
            end
        end
`ifdef OLED_CLEAR_EN
        begin
            int p3;
            p3 = INIT_N + 3 * (3 + COLS);
            checks++;
            if (sz <= p3 + 3 || log_data[p3] !== 8'hB3 || log_data[p3+1] !== 8'h00 ||
                log_data[p3+2] !== 8'h10 || log_addr[p3+3] !== 16'h0040) begin
                errors++; $display("FAIL clr_page3_header got=%h %h %h addr=%h exp=b3 00 10 addr=0040",
                                   log_data[p3], log_data[p3+1], log_data[p3+2], log_addr[p3+3]);
            end
        end
`endif
    endtask

    task automatic test_usr_write;
        int creq, cex, cack;
        logic rdy_ex, rdy_ack, rdy_after;
        logic c;
        logic [7:0] b;
        int sz;
        fixed_dly = 0;
        for (int t = 0; t < 8; t++) begin
            c  = (t == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            b  = (t == 0) ? 8'h5A : 8'($urandom);
            sz = log_data.size();
            do_write(c, b, creq, cex, cack, rdy_ex, rdy_ack, rdy_after);
            checks++; if (cex != creq + 1) begin errors++; $display("FAIL usr_exec_latency[%0d] got=%0d exp=%0d", t, cex - creq, 1); end
            checks++;
            if (log_data.size() != sz + 1 || log_data[sz] !== b || log_addr[sz] !== (c ? 16'h0000 : 16'h0040)) begin
                errors++; $display("FAIL usr_txn[%0d] got=%h/%h exp=%h/%h", t, log_addr[sz], log_data[sz], (c ? 16'h0000 : 16'h0040), b);
            end
            checks++; if (cack != done_cyc + 1) begin errors++; $display("FAIL usr_ack_latency[%0d] got=%0d exp=%0d", t, cack, done_cyc + 1); end
            checks++;
            if (rdy_ex !== 1'b0 || rdy_ack !== 1'b0 || rdy_after !== 1'b1) begin
                errors++; $display("FAIL usr_ready_seq[%0d] got=%b%b%b exp=001", t, rdy_ex, rdy_ack, rdy_after);
            end
        end
    endtask

    task automatic test_done_at_terminal;
        int creq, cex, cack;
        logic rdy_ex, rdy_ack, rdy_after;
        fixed_dly = int'(TIMEOUT) - 1;
        do_write(1'b1, 8'hC3, creq, cex, cack, rdy_ex, rdy_ack, rdy_after);
        checks++; if (cack != cex + int'(TIMEOUT)) begin errors++; $display("FAIL term_ack_cycle got=%0d exp=%0d", cack - cex, int'(TIMEOUT)); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL term_err got=%b exp=0", err); end
        fixed_dly = 0;
        do_write(1'b0, 8'h3C, creq, cex, cack, rdy_ex, rdy_ack, rdy_after);
        checks++; if (rdy_after !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL term_proceed ready=%b err=%b exp ready=1 err=0", rdy_after, err); end
    endtask

    task automatic test_reset_mid;
        int rel;
        int n;
        int first;
        fixed_dly = 3;
        rst_n = 1'b0;
        tick();
        release_reset(rel);
        n = 0;
        while (log_data.size() <= MID_IDX && n < 5000) begin tick(); n++; end
        checks++; if (log_data.size() <= MID_IDX) begin errors++; $display("FAIL mid_progress got=%0d exp>%0d", log_data.size(), MID_IDX); end
        @(posedge i2c_clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (drv_exec !== 1'b0 || usr_ack !== 1'b0 || ready !== 1'b0 || err !== 1'b0 ||
            drv_word_addr !== 16'h0000 || drv_wdata !== 8'h00) begin
            errors++; $display("FAIL mid_rst_outputs got exec=%b ack=%b rdy=%b err=%b addr=%h wd=%h exp all zero",
                               drv_exec, usr_ack, ready, err, drv_word_addr, drv_wdata);
        end
        repeat (2) tick();
        release_reset(rel);
        n = 0;
        while (ready !== 1'b1 && n < 5000) begin tick(); n++; end
        first = (log_cyc.size() > 0) ? log_cyc[0] - rel : -1;
        checks++; if (first != int'(PWR_DLY) + 1) begin errors++; $display("FAIL mid_first_exec_cycle got=%0d exp=%0d", first, int'(PWR_DLY) + 1); end
        checks++;
        if (log_data.size() == 0 || log_data[0] !== rom_ref[0] || log_addr[0] !== 16'h0000) begin
            errors++; $display("FAIL mid_first_byte got=%h/%h exp=0000/%h", log_addr[0], log_data[0], rom_ref[0]);
        end
        checks++; if (log_data.size() != SEQ_N) begin errors++; $display("FAIL mid_replay_count got=%0d exp=%0d", log_data.size(), SEQ_N); end
    endtask

    task automatic test_timeout;
        int n;
        int cex;
        int cerr;
        int sz;
        int bad;
        withhold = 1;
        n = 0;
        while (ready !== 1'b1 && n < 500) begin tick(); n++; end
        usr_cmd  = 1'b1;
        usr_byte = 8'hE3;
        usr_req  = 1'b1;
        n = 0;
        do begin tick(); n++; end while (drv_exec !== 1'b1 && n < 500);
        cex = cyc;
        sz  = log_data.size();
        n = 0;
        while (err !== 1'b1 && n < int'(TIMEOUT) + 100) begin tick(); n++; end
        cerr = cyc;
        checks++; if (err !== 1'b1 || cerr != cex + int'(TIMEOUT)) begin errors++; $display("FAIL timeout_err_cycle got=%0d err=%b exp=%0d", cerr - cex, err, int'(TIMEOUT)); end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (ready !== 1'b0 || drv_exec !== 1'b0 || err !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL error_terminal bad_cycles=%0d exp=0", bad); end
        checks++; if (log_data.size() != sz) begin errors++; $display("FAIL error_no_exec got=%0d exp=%0d", log_data.size(), sz); end
        usr_req  = 1'b0;
        withhold = 0;
    endtask

    task automatic test_protocol;
        checks++; if (stab_bad != 0) begin errors++; $display("FAIL payload_stability violations=%0d exp=0", stab_bad); end
        checks++; if (gap_bad != 0)  begin errors++; $display("FAIL exec_gap violations=%0d exp=0", gap_bad); end
    endtask

    initial begin
        rst_n    = 1'b0;
        usr_req  = 1'b0;
        usr_cmd  = 1'b0;
        usr_byte = 8'h00;
        test_reset();
        test_init();
        test_usr_write();
        test_done_at_terminal();
        test_reset_mid();
        test_timeout();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
